// File: rtl/rv32_run_monitor.sv
// rv32_run_monitor: watches an RV32 core's retirement stream and halts the run
// when the retired PC sequence settles into a short repeating loop, or when an
// enabled-cycle budget runs out. Loop detection beats timeout on the same edge.
module rv32_run_monitor #(
  parameter int MAX_PERIOD = 4,
  parameter int REPEATS    = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             instruction_done,
  input  logic [31:0]      PC,
  input  logic [CNT_W-1:0] max_cycles,
  output logic             done,
  output logic [1:0]       reason,
  output logic [31:0]      loop_pc,
  output logic [4:0]       loop_period,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instructions_retired
);

  // Run counters hold up to 16*15; the valid count holds up to 16.
  localparam int RUN_W  = 8;
  localparam int VCNT_W = 5;

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t             state_r;
  logic               done_r;
  logic [1:0]         reason_r;
  logic [31:0]        loop_pc_r;
  logic [4:0]         loop_period_r;
  logic [CNT_W-1:0]   cycles_r;
  logic [CNT_W-1:0]   retired_r;

  // hist_r[i] is the PC retired (i+1) retirements ago; run_r[i] tracks period i+1.
  logic [31:0]        hist_r [MAX_PERIOD];
  logic [VCNT_W-1:0]  vcnt_r;
  logic [RUN_W-1:0]   run_r  [MAX_PERIOD];
  logic [RUN_W-1:0]   run_s  [MAX_PERIOD];

  logic               accept_s;
  logic               retire_s;
  logic [CNT_W-1:0]   cycles_inc_s;
  logic [CNT_W-1:0]   retired_inc_s;
  logic               timeout_s;
  logic               loop_s;
  logic [4:0]         loop_p_s;

  // Number of consecutive matches that completes REPEATS identical iterations.
  function automatic logic [RUN_W-1:0] run_target(input int p);
    return RUN_W'(p * (REPEATS - 1));
  endfunction

  // Edge qualification, saturating increments, run-length update and halt detection.
  always_comb begin
    accept_s      = ena && (state_r == S_RUN);
    retire_s      = accept_s && instruction_done;
    cycles_inc_s  = (cycles_r  == {CNT_W{1'b1}}) ? cycles_r  : cycles_r  + CNT_W'(1);
    retired_inc_s = (retired_r == {CNT_W{1'b1}}) ? retired_r : retired_r + CNT_W'(1);
    timeout_s     = accept_s && (max_cycles != {CNT_W{1'b0}}) && (cycles_inc_s == max_cycles);
    loop_p_s      = 5'd0;
    // Descending scan so the smallest detected period is the one that sticks.
    for (int i = MAX_PERIOD - 1; i >= 0; i--) begin
      if ((vcnt_r > VCNT_W'(i)) && (PC == hist_r[i])) begin
        run_s[i] = (run_r[i] == run_target(i + 1)) ? run_r[i] : run_r[i] + RUN_W'(1);
      end else begin
        run_s[i] = {RUN_W{1'b0}};
      end
      loop_p_s = (run_s[i] == run_target(i + 1)) ? 5'(i + 1) : loop_p_s;
    end
    loop_s = retire_s && (loop_p_s != 5'd0);
  end

  // State, counters, PC history and halt outputs; only accepted edges change anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_RUN;
      done_r        <= 1'b0;
      reason_r      <= 2'b00;
      loop_pc_r     <= 32'h0;
      loop_period_r <= 5'd0;
      cycles_r      <= {CNT_W{1'b0}};
      retired_r     <= {CNT_W{1'b0}};
      vcnt_r        <= {VCNT_W{1'b0}};
      for (int i = 0; i < MAX_PERIOD; i++) begin
        hist_r[i] <= 32'h0;
        run_r[i]  <= {RUN_W{1'b0}};
      end
    end else if (accept_s) begin
      cycles_r <= cycles_inc_s;
      if (retire_s) begin
        retired_r <= retired_inc_s;
        hist_r[0] <= PC;
        for (int i = 1; i < MAX_PERIOD; i++) begin
          hist_r[i] <= hist_r[i-1];
        end
        if (vcnt_r != VCNT_W'(MAX_PERIOD)) begin
          vcnt_r <= vcnt_r + VCNT_W'(1);
        end else begin
          vcnt_r <= vcnt_r;
        end
        for (int i = 0; i < MAX_PERIOD; i++) begin
          run_r[i] <= run_s[i];
        end
      end else begin
        retired_r <= retired_r;
      end
      if (loop_s) begin
        state_r       <= S_HALTED;
        done_r        <= 1'b1;
        reason_r      <= 2'b01;
        loop_pc_r     <= PC;
        loop_period_r <= loop_p_s;
      end else if (timeout_s) begin
        state_r  <= S_HALTED;
        done_r   <= 1'b1;
        reason_r <= 2'b10;
      end else begin
        state_r  <= state_r;
      end
    end else begin
      state_r <= state_r;
    end
  end

  assign done                 = done_r;
  assign reason               = reason_r;
  assign loop_pc              = loop_pc_r;
  assign loop_period          = loop_period_r;
  assign cycles               = cycles_r;
  assign instructions_retired = retired_r;

endmodule

// File: tb/tb_rv32_run_monitor.sv
// Directed bench for rv32_run_monitor with default parameters.
module tb_rv32_run_monitor;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        instruction_done;
  logic [31:0] PC;
  logic [31:0] max_cycles;
  logic        done;
  logic [1:0]  reason;
  logic [31:0] loop_pc;
  logic [4:0]  loop_period;
  logic [31:0] cycles;
  logic [31:0] instructions_retired;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  rv32_run_monitor #(.MAX_PERIOD(4), .REPEATS(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ena(ena), .instruction_done(instruction_done),
    .PC(PC), .max_cycles(max_cycles), .done(done), .reason(reason),
    .loop_pc(loop_pc), .loop_period(loop_period), .cycles(cycles),
    .instructions_retired(instructions_retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic with_ena);
    rst = 1'b1; ena = with_ena; instruction_done = 1'b1; PC = 32'h18;
    tick();
    rst = 1'b0; ena = 1'b0; instruction_done = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc);
    ena = 1'b1; instruction_done = 1'b1; PC = pc;
    tick();
    ena = 1'b0; instruction_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ena = 1'b1; instruction_done = 1'b0;
      tick();
    end
    ena = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".done"},    64'(done),                 64'd0);
    check({tag, ".reason"},  64'(reason),               64'd0);
    check({tag, ".loop_pc"}, 64'(loop_pc),              64'd0);
    check({tag, ".period"},  64'(loop_period),          64'd0);
    check({tag, ".cycles"},  64'(cycles),               64'd0);
    check({tag, ".retired"}, 64'(instructions_retired), 64'd0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; ena = 1'b0; instruction_done = 1'b0;
    PC = 32'h0; max_cycles = 32'd0;

    // Reset with ena low still clears everything.
    do_reset(1'b0);
    check_zero("reset");

    // Self-loop: 0x10, 0x14, then 0x18 repeatedly.
    retire(32'h10); retire(32'h14);
    retire(32'h18); retire(32'h18); retire(32'h18);
    check("self.early_done", 64'(done), 64'd0);
    retire(32'h18);
    check("self.done",    64'(done),                 64'd1);
    check("self.reason",  64'(reason),               64'd1);
    check("self.loop_pc", 64'(loop_pc),              64'h18);
    check("self.period",  64'(loop_period),          64'd1);
    check("self.retired", 64'(instructions_retired), 64'd6);
    check("self.cycles",  64'(cycles),               64'd6);
    // Halted: further retirements are ignored.
    retire(32'h40); retire(32'h44);
    check("halt.cycles",  64'(cycles),               64'd6);
    check("halt.retired", 64'(instructions_retired), 64'd6);
    check("halt.done",    64'(done),                 64'd1);

    // Period-2 loop.
    do_reset(1'b1);
    check_zero("reset2");
    for (int i = 0; i < 7; i++) retire((i % 2 == 0) ? 32'h20 : 32'h24);
    check("p2.early_done", 64'(done), 64'd0);
    retire(32'h24);
    check("p2.done",    64'(done),        64'd1);
    check("p2.reason",  64'(reason),      64'd1);
    check("p2.loop_pc", 64'(loop_pc),     64'h24);
    check("p2.period",  64'(loop_period), 64'd2);

    // Freeze: ena low with retirements presented must change nothing.
    do_reset(1'b0);
    retire(32'h18); retire(32'h18);
    ena = 1'b0; instruction_done = 1'b1; PC = 32'h18;
    for (int i = 0; i < 20; i++) tick();
    instruction_done = 1'b0;
    check("frz.cycles",  64'(cycles),               64'd2);
    check("frz.retired", 64'(instructions_retired), 64'd2);
    check("frz.done",    64'(done),                 64'd0);
    retire(32'h18);
    check("frz.hist_done3", 64'(done), 64'd0);
    retire(32'h18);
    check("frz.hist_done4", 64'(done),                 64'd1);
    check("frz.retired4",   64'(instructions_retired), 64'd4);
    check("frz.cycles4",    64'(cycles),               64'd4);

    // Reset mid-loop discards partial evidence.
    do_reset(1'b0);
    retire(32'h18); retire(32'h18); retire(32'h18);
    do_reset(1'b1);
    check_zero("midrst");
    retire(32'h18); retire(32'h18); retire(32'h18);
    check("midrst.early_done", 64'(done), 64'd0);
    retire(32'h18);
    check("midrst.done",    64'(done),                 64'd1);
    check("midrst.retired", 64'(instructions_retired), 64'd4);
    check("midrst.period",  64'(loop_period),          64'd1);

    // Timeout at 100 with strictly increasing PCs.
    do_reset(1'b0);
    max_cycles = 32'd100;
    for (int i = 0; i < 99; i++) retire(32'h1000 + 32'(i * 4));
    check("to.early_done", 64'(done),   64'd0);
    check("to.cycles99",   64'(cycles), 64'd99);
    retire(32'h2000);
    check("to.done",    64'(done),        64'd1);
    check("to.reason",  64'(reason),      64'd2);
    check("to.cycles",  64'(cycles),      64'd100);
    check("to.period",  64'(loop_period), 64'd0);
    check("to.loop_pc", 64'(loop_pc),     64'd0);

    // max_cycles = 0 disables the timeout.
    do_reset(1'b0);
    max_cycles = 32'd0;
    for (int i = 0; i < 1000; i++) retire(32'h4000 + 32'(i * 4));
    check("noto.done",   64'(done),   64'd0);
    check("noto.cycles", 64'(cycles), 64'd1000);

    // Loop and timeout on the same edge: loop wins.
    do_reset(1'b0);
    max_cycles = 32'd4;
    retire(32'h18); retire(32'h18); retire(32'h18);
    check("tie.early_done", 64'(done), 64'd0);
    retire(32'h18);
    check("tie.done",    64'(done),        64'd1);
    check("tie.reason",  64'(reason),      64'd1);
    check("tie.period",  64'(loop_period), 64'd1);
    check("tie.loop_pc", 64'(loop_pc),     64'h18);

    // Lowering max_cycles below the count never fires; raising it does.
    do_reset(1'b0);
    max_cycles = 32'd0;
    idle(5);
    max_cycles = 32'd3;
    idle(10);
    check("mc.low_done",   64'(done),   64'd0);
    check("mc.low_cycles", 64'(cycles), 64'd15);
    max_cycles = 32'd20;
    idle(4);
    check("mc.early_done", 64'(done), 64'd0);
    idle(1);
    check("mc.done",   64'(done),   64'd1);
    check("mc.reason", 64'(reason), 64'd2);
    check("mc.cycles", 64'(cycles), 64'd20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
